// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage with a valid/ready handshake, stall and flush.
// SKID_EN selects a 2-entry skid buffer (registered ReadyE) or a single register.
module ex_mem_pipe_stage #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int SKID_EN  = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FlushE,
   input  logic              ValidE,
   output logic              ReadyE,
   input  logic [DATA_W-1:0] ALUOutE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   output logic              ValidM,
   input  logic              ReadyM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [REG_AW-1:0] WriteRegM,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              MemWriteM
);

   localparam int ENTRY_W = 2*DATA_W + REG_AW + 3;

   logic [ENTRY_W-1:0] entryIn;
   logic [ENTRY_W-1:0] head;
   logic               validHead;
   logic               capRegWrite;
   logic               headRegWrite;
   logic               headMemtoReg;
   logic               headMemWrite;

   // Register $0 is hardwired, so a write to it is dropped at capture time
   assign capRegWrite = (ZERO_REG != 0) ? (RegWriteE & (WriteRegE != '0)) : RegWriteE;
   assign entryIn     = {ALUOutE, WriteDataE, WriteRegE, capRegWrite, MemtoRegE, MemWriteE};

   assign {ALUOutM, WriteDataM, WriteRegM, headRegWrite, headMemtoReg, headMemWrite} = head;
   assign ValidM    = validHead;
   assign RegWriteM = headRegWrite & validHead;
   assign MemtoRegM = headMemtoReg & validHead;
   assign MemWriteM = headMemWrite & validHead;

   generate
      if (SKID_EN != 0) begin : gSkid
         typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

         state_t             state;
         state_t             nextState;
         logic [ENTRY_W-1:0] mainQ;
         logic [ENTRY_W-1:0] skidQ;
         logic               readyQ;
         logic               inXfer;
         logic               outXfer;
         logic               loadMainIn;
         logic               loadMainSkid;
         logic               loadSkid;

         assign inXfer  = ValidE & readyQ;
         assign outXfer = (state != EMPTY) & ReadyM;

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) state <= EMPTY;
            else      state <= nextState;
         end

         // Flush wins over every transition; a head leaving in a flush cycle still counts as sent
         always_comb begin
            nextState    = state;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
            if (FlushE) begin
               nextState = EMPTY;
            end else begin
               case (state)
                  EMPTY: begin
                     if (inXfer) begin
                        nextState  = FULL1;
                        loadMainIn = 1'b1;
                     end
                  end
                  FULL1: begin
                     if (inXfer && outXfer) begin
                        loadMainIn = 1'b1;
                     end else if (inXfer) begin
                        nextState = FULL2;
                        loadSkid  = 1'b1;
                     end else if (outXfer) begin
                        nextState = EMPTY;
                     end
                  end
                  FULL2: begin
                     if (outXfer) begin
                        nextState    = FULL1;
                        loadMainSkid = 1'b1;
                     end
                  end
                  default: nextState = EMPTY;
               endcase
            end
         end

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) readyQ <= 1'b1;
            else      readyQ <= (nextState != FULL2);
         end

         // Skid always holds the younger entry, so it only ever refills main
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               mainQ <= '0;
               skidQ <= '0;
            end else begin
               if (loadMainIn)        mainQ <= entryIn;
               else if (loadMainSkid) mainQ <= skidQ;
               if (loadSkid)          skidQ <= entryIn;
            end
         end

         assign head      = mainQ;
         assign validHead = (state != EMPTY);
         assign ReadyE    = readyQ;
      end else begin : gReg
         logic [ENTRY_W-1:0] regQ;
         logic               validQ;
         logic               inXfer;
         logic               outXfer;

         assign ReadyE  = ReadyM | ~validQ;
         assign inXfer  = ValidE & ReadyE;
         assign outXfer = validQ & ReadyM;

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               regQ   <= '0;
               validQ <= 1'b0;
            end else if (FlushE) begin
               validQ <= 1'b0;
            end else if (inXfer) begin
               regQ   <= entryIn;
               validQ <= 1'b1;
            end else if (outXfer) begin
               validQ <= 1'b0;
            end
         end

         assign head      = regQ;
         assign validHead = validQ;
      end
   endgenerate

endmodule
